// File: rtl/nand_gate_tester.sv
// Drives the four input combinations of an external 2-input NAND, samples its
// output after a programmable settle time and accumulates a mismatch report.
module nand_gate_tester #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned SWEEPS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE);
    localparam logic [3:0] SWEEP_LAST  = 4'(SWEEPS - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] sweep_q, sweep_d;
    logic [3:0] settle_q, settle_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [7:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;

    logic       mismatch;
    logic [7:0] err_sampled;
    logic [1:0] idx_next;
    logic       final_sample;

    assign mismatch     = (y_in != ~(a_q & b_q));
    assign err_sampled  = (mismatch && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    assign idx_next     = idx_q + 2'd1;
    assign final_sample = (idx_q == 2'd3) && (sweep_q == SWEEP_LAST);

    // NOTE: every _d gets its hold value first, so no path through the case leaves a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sweep_d  = sweep_q;
        settle_d = settle_q;
        a_d      = a_q;
        b_d      = b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        fail_d   = fail_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_HOLD;
                    busy_d   = 1'b1;
                    idx_d    = 2'd0;
                    sweep_d  = 4'd0;
                    settle_d = SETTLE_LOAD;
                    a_d      = 1'b0;
                    b_d      = 1'b0;
                    err_d    = 8'd0;
                    fail_d   = 4'd0;
                    pass_d   = 1'b0;
                end
            end
            S_HOLD: begin
                if (abort) begin
                    // Partial error results stay visible; the pending sample is dropped.
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    pass_d  = 1'b0;
                end else if (settle_q != 4'd0) begin
                    settle_d = settle_q - 4'd1;
                end else begin
                    err_d  = err_sampled;
                    fail_d = mismatch ? (fail_q | (4'b0001 << idx_q)) : fail_q;
                    if (final_sample) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        pass_d  = (err_sampled == 8'd0);
                    end else begin
                        idx_d    = idx_next;
                        sweep_d  = (idx_q == 2'd3) ? sweep_q + 4'd1 : sweep_q;
                        settle_d = SETTLE_LOAD;
                        a_d      = idx_next[1];
                        b_d      = idx_next[0];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            sweep_q  <= 4'd0;
            settle_q <= 4'd0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 8'd0;
            fail_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sweep_q  <= sweep_d;
            settle_q <= settle_d;
            a_q      <= a_d;
            b_q      <= b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: doc/nand_gate_tester.md
NAND_GATE_TESTER -- requirements
Module: nand_gate_tester

Interface
REQ-001 Parameter SETTLE, default 2, range 1..15: idle cycles each vector is held before y_in is sampled.
REQ-002 Parameter SWEEPS, default 1, range 1..15: number of full 4-vector truth-table sweeps per run.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 abort  input  1  cancels a run in progress.
REQ-007 y_in  input  1  output of the 2-input NAND under test, combinational from a_out/b_out, same clock domain.
REQ-008 a_out  output  1  registered drive to the gate's a input.
REQ-009 b_out  output  1  registered drive to the gate's b input.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  one-cycle pulse at run completion.
REQ-012 pass  output  1  high when the last completed run had zero mismatches.
REQ-013 err_count  output  8  mismatches in the last or current run.
REQ-014 fail_vec  output  4  bit i set when vector i mismatched at least once.

Function
REQ-015 States: IDLE, HOLD, DONE. DONE lasts exactly one cycle, then IDLE.
REQ-016 Vector index idx 0..3 maps to a_out=idx[1], b_out=idx[0]; order 00, 01, 10, 11.
REQ-017 IDLE with start=1 at edge E: state HOLD, busy=1, idx=0, a_out=b_out=0, err_count=0, fail_vec=0, pass=0; all take effect after E.
REQ-018 Each vector is held exactly SETTLE+1 cycles; y_in is sampled at the last edge of that hold.
REQ-019 Expected value = NOT(a_out AND b_out); mismatch when y_in differs.
REQ-020 On mismatch: err_count increments, saturating at 255; fail_vec[idx] set (sticky for the run).
REQ-021 After a non-final sample: idx advances, wrapping 3->0 at sweep end; new vector driven from the same edge.
REQ-022 Final sample (idx=3, last sweep), at edge F=E+4*(SETTLE+1)*SWEEPS:
  - busy=0, done=1 for one cycle
  - a_out=b_out=0
  - pass=1 iff final err_count==0, including this sample's result
REQ-023 err_count, fail_vec and pass hold after done until the next accepted start.
REQ-024 start while busy or in DONE is ignored; no queuing.
REQ-025 abort=1 while busy: next state IDLE; busy=0, a_out=b_out=0, done stays 0, pass=0; err_count and fail_vec keep their partial values.
REQ-026 abort in IDLE has no effect.
REQ-027 If abort and a final sample coincide, abort wins: no done, and the sample is discarded.
REQ-028 The settle counter is 4 bits and is reloaded on every vector change.

Reset
REQ-029 rst=1 at an edge overrides start and abort. Result: state IDLE; a_out, b_out, busy, done, pass = 0; err_count=0; fail_vec=0.
REQ-030 Reset mid-run aborts silently: no done pulse, and counters clear.

Verification
REQ-031 Correct NAND, SETTLE=2, SWEEPS=1, start at edge 0 -> samples at edges 3, 6, 9, 12; done high only in the cycle after edge 12; pass=1, err_count=0, fail_vec=0000.
REQ-032 Gate model stuck-at-1 -> vector 11 mismatches; done: pass=0, err_count=1, fail_vec=1000.
REQ-033 Gate model replaced by AND, SWEEPS=3 -> err_count=12, fail_vec=1111, pass=0.
REQ-034 Inverted-gate model, SETTLE=15, SWEEPS=15 -> err_count=60; done at edge 4*16*15=960 after start.
REQ-035 start pulsed again mid-run -> ignored, timing unchanged. abort at edge 5 -> busy=0 at edge 6, no done, a_out=b_out=0.
REQ-036 rst at edge 7 of a run -> all outputs 0 after edge 7, no done. A subsequent start runs normally to completion.
